// File: rtl/rvv_vreg_writer.sv
// rvv_vreg_writer: write-side sequencer for the vector register file.
// Packs a stream of SEW-wide elements into VLEN-bit register words across an
// LMUL group and issues one strobed write per touched register.
// Optional feature macro: RVV_WRITER_MASK_EN (adds the elem_mask input).

// One byte lane of the accumulator: merges an element byte into this lane
// when the element's byte range covers it.
module rvv_vreg_writer_lane #(
    parameter int LANE = 0,
    parameter int XLEN = 32,
    parameter int LBW  = 4
) (
    input  logic [LBW-1:0]  off,
    input  logic [1:0]      sew,
    input  logic            wr_en,
    input  logic [XLEN-1:0] data,
    input  logic [7:0]      acc_byte,
    input  logic            acc_strb,
    output logic [7:0]      nxt_byte,
    output logic            nxt_strb
);
    int         rel;
    int         nb;
    logic       hit;
    logic [1:0] bsel;

    // Select which element byte (if any) lands in this lane
    always_comb begin
        rel      = LANE - int'(off);
        nb       = 1 << sew;
        hit      = wr_en && (rel >= 0) && (rel < nb);
        bsel     = rel[1:0];
        nxt_byte = hit ? data[{bsel, 3'b000} +: 8] : acc_byte;
        nxt_strb = acc_strb | hit;
    end
endmodule

module rvv_vreg_writer #(
    parameter int VLEN = 128,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_vd,
    input  logic [1:0]        cmd_sew,
    input  logic [1:0]        cmd_lmul,
    input  logic [10:0]       cmd_vl,
    input  logic [10:0]       cmd_vstart,
    input  logic              elem_valid,
    output logic              elem_ready,
`ifdef RVV_WRITER_MASK_EN
    input  logic              elem_mask,
`endif
    input  logic [XLEN-1:0]   elem_data,
    output logic [4:0]        vreg_waddr,
    output logic [VLEN/8-1:0] vreg_wstrb,
    output logic [VLEN-1:0]   vreg_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int VLENB = VLEN / 8;
    localparam int LBW   = $clog2(VLENB);

    typedef enum logic {IDLE, RUN} state_e;

    // Command fields held for the duration of RUN
    typedef struct packed {
        logic [4:0]  vd;
        logic [1:0]  sew;
        logic [10:0] vl;
    } cmd_t;

    state_e                 state_q, state_d;
    cmd_t                   cmd_q, cmd_d;
    logic [10:0]            idx_q, idx_d;
    logic [VLENB-1:0][7:0]  acc_q, acc_d, acc_m;
    logic [VLENB-1:0]       strb_q, strb_d, strb_m;
    logic [4:0]             waddr_q, waddr_d;
    logic [VLENB-1:0]       wstrb_q, wstrb_d;
    logic [VLEN-1:0]        wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   mask;
    logic                   accept, wr_en, last_elem, last_in_reg, flush;
    logic                   illegal;
    logic [LBW-1:0]         epr_m1, off;
    logic [4:0]             vd_m;
    int                     vlmax;
    int                     sh;

`ifdef RVV_WRITER_MASK_EN
    assign mask = elem_mask;
`else
    assign mask = 1'b1;
`endif

    // Element position within the current register and flush decision
    always_comb begin
        accept      = (state_q == RUN) && elem_valid;
        wr_en       = accept && mask;
        epr_m1      = LBW'(VLENB - 1) >> cmd_q.sew;
        off         = (idx_q[LBW-1:0] & epr_m1) << cmd_q.sew;
        last_in_reg = (idx_q[LBW-1:0] & epr_m1) == epr_m1;
        last_elem   = idx_q == (cmd_q.vl - 11'd1);
        flush       = accept && (last_in_reg || last_elem);
        sh          = LBW - int'(cmd_q.sew);
    end

    // Command legality: SEW, group alignment and vl against VLMAX
    always_comb begin
        vd_m    = (5'd1 << cmd_lmul) - 5'd1;
        vlmax   = (VLEN << cmd_lmul) >> (3 + int'(cmd_sew));
        illegal = (cmd_sew == 2'd3) || ((cmd_vd & vd_m) != 5'd0) || (int'(cmd_vl) > vlmax);
    end

    for (genvar b = 0; b < VLENB; b++) begin : g_lane
        rvv_vreg_writer_lane #(.LANE(b), .XLEN(XLEN), .LBW(LBW)) u_lane (
            .off      (off),
            .sew      (cmd_q.sew),
            .wr_en    (wr_en),
            .data     (elem_data),
            .acc_byte (acc_q[b]),
            .acc_strb (strb_q[b]),
            .nxt_byte (acc_m[b]),
            .nxt_strb (strb_m[b])
        );
    end

    // Next-state, accumulator and registered-output computation
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        strb_d  = strb_q;
        waddr_d = '0;
        wstrb_d = '0;
        wdata_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (cmd_vstart >= cmd_vl) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        cmd_d.vd  = cmd_vd;
                        cmd_d.sew = cmd_sew;
                        cmd_d.vl  = cmd_vl;
                        idx_d     = cmd_vstart;
                        acc_d     = '0;
                        strb_d    = '0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    idx_d  = idx_q + 11'd1;
                    acc_d  = acc_m;
                    strb_d = strb_m;
                    if (flush) begin
                        // All-masked registers flush with wstrb=0, i.e. no write
                        waddr_d = cmd_q.vd + 5'(idx_q >> sh);
                        wstrb_d = strb_m;
                        wdata_d = acc_m;
                        acc_d   = '0;
                        strb_d  = '0;
                    end
                    if (last_elem) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial group
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            strb_q  <= '0;
            waddr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            strb_q  <= strb_d;
            waddr_q <= waddr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE) && resetn;
    assign elem_ready = state_q == RUN;
    assign busy       = state_q != IDLE;
    assign vreg_waddr = waddr_q;
    assign vreg_wstrb = wstrb_q;
    assign vreg_wdata = wdata_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_rvv_vreg_writer.sv
// Scoreboard bench for rvv_vreg_writer at VLEN=32 (4 bytes per register).
module tb_rvv_vreg_writer;
    localparam int VLEN  = 32;
    localparam int XLEN  = 32;
    localparam int VLENB = VLEN / 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [4:0]        cmd_vd = '0;
    logic [1:0]        cmd_sew = '0;
    logic [1:0]        cmd_lmul = '0;
    logic [10:0]       cmd_vl = '0;
    logic [10:0]       cmd_vstart = '0;
    logic              elem_valid = 1'b0;
    logic              elem_ready;
    logic              elem_mask = 1'b1;
    logic [XLEN-1:0]   elem_data = '0;
    logic [4:0]        vreg_waddr;
    logic [VLENB-1:0]  vreg_wstrb;
    logic [VLEN-1:0]   vreg_wdata;
    logic              busy, done, err;

    always #5 clk = ~clk;

    rvv_vreg_writer #(.VLEN(VLEN), .XLEN(XLEN)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_vd     (cmd_vd),
        .cmd_sew    (cmd_sew),
        .cmd_lmul   (cmd_lmul),
        .cmd_vl     (cmd_vl),
        .cmd_vstart (cmd_vstart),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
`ifdef RVV_WRITER_MASK_EN
        .elem_mask  (elem_mask),
`endif
        .elem_data  (elem_data),
        .vreg_waddr (vreg_waddr),
        .vreg_wstrb (vreg_wstrb),
        .vreg_wdata (vreg_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        done;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ed [16];
    logic [15:0] em;
    exp_t        mon_e;
    logic        mon_bad;

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic push_exp(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d,
                            input logic dn, input logic er);
        exp_t e;
        e.waddr = a; e.wstrb = s; e.wdata = d; e.done = dn; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Monitor: every write/done/err event must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && (vreg_wstrb != '0 || done || err)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event waddr=%0d wstrb=%h wdata=%h done=%b err=%b",
                             vreg_waddr, vreg_wstrb, vreg_wdata, done, err);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_bad = (vreg_wstrb !== mon_e.wstrb) || (done !== mon_e.done) ||
                              (err !== mon_e.err) ||
                              ((vreg_wdata & bmask(mon_e.wstrb)) !== (mon_e.wdata & bmask(mon_e.wstrb))) ||
                              ((mon_e.wstrb != 4'h0) && (vreg_waddr !== mon_e.waddr));
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL write_event got a=%0d s=%h d=%h dn=%b er=%b expected a=%0d s=%h d=%h dn=%b er=%b",
                                 vreg_waddr, vreg_wstrb, vreg_wdata, done, err,
                                 mon_e.waddr, mon_e.wstrb, mon_e.wdata, mon_e.done, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic issue_cmd(input logic [4:0] vd, input logic [1:0] sew, input logic [1:0] lmul,
                             input logic [10:0] vl, input logic [10:0] vst);
        int n = 0;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout got=0 expected=1");
        end
        cmd_valid = 1'b1; cmd_vd = vd; cmd_sew = sew; cmd_lmul = lmul;
        cmd_vl = vl; cmd_vstart = vst;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_elems(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            elem_valid = 1'b1; elem_data = ed[k]; elem_mask = em[k];
            while (!elem_ready && w < 20) begin @(posedge clk); #1; w++; end
            if (!elem_ready) begin
                checks++; errors++;
                $display("FAIL elem_ready_timeout got=0 expected=1");
                elem_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gap > 0) begin
                elem_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        elem_valid = 1'b0;
    endtask

    initial begin
        em = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wstrb", 32'(vreg_wstrb), 32'h0);
        chk("rst_wdata", vreg_wdata, 32'h0);
        chk("rst_busy_done_err", {29'h0, busy, done, err}, 32'h0);
        chk("rst_elem_ready", 32'(elem_ready), 32'h0);
        resetn = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);

        // sew8 single register
        push_exp(5'd4, 4'hf, 32'h67452301, 1'b1, 1'b0);
        ed[0] = 32'h01; ed[1] = 32'h23; ed[2] = 32'h45; ed[3] = 32'h67;
        issue_cmd(5'd4, 2'd0, 2'd0, 11'd4, 11'd0);
        chk("run_busy", 32'(busy), 32'h1);
        send_elems(4, 0);

        // sew32 across a two-register group, back-to-back
        push_exp(5'd2, 4'hf, 32'hAABBCCDD, 1'b0, 1'b0);
        push_exp(5'd3, 4'hf, 32'h11223344, 1'b1, 1'b0);
        ed[0] = 32'hAABBCCDD; ed[1] = 32'h11223344;
        issue_cmd(5'd2, 2'd2, 2'd1, 11'd2, 11'd0);
        send_elems(2, 0);

        // sew16 with vstart=1: prestart bytes untouched
        push_exp(5'd1, 4'hc, 32'hBEEF0000, 1'b1, 1'b0);
        ed[0] = 32'h0000BEEF;
        issue_cmd(5'd1, 2'd1, 2'd0, 11'd2, 11'd1);
        send_elems(1, 0);

        // illegal commands: misaligned vd, sew=3, vl above VLMAX
        push_exp(5'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        issue_cmd(5'd3, 2'd0, 2'd1, 11'd1, 11'd0);
        chk("err_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("err_busy", 32'(busy), 32'h0);
        push_exp(5'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        issue_cmd(5'd0, 2'd3, 2'd0, 11'd1, 11'd0);
        chk("err_sew3_cmd_ready", 32'(cmd_ready), 32'h1);
        push_exp(5'd0, 4'h0, 32'h0, 1'b0, 1'b1);
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd5, 11'd0);
        @(posedge clk); #1;

        // reset mid-command: nothing written, no done
        ed[0] = 32'h5A; ed[1] = 32'hA5;
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd4, 11'd0);
        send_elems(2, 0);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_wstrb", 32'(vreg_wstrb), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        resetn = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
        repeat (2) begin @(posedge clk); #1; end

        // fresh partial command after reset: no stale strobes
        push_exp(5'd0, 4'h3, 32'h0000CDAB, 1'b1, 1'b0);
        ed[0] = 32'hAB; ed[1] = 32'hCD;
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd2, 11'd0);
        send_elems(2, 0);

        // empty bodies: vl==0 and vstart>=vl
        push_exp(5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd0, 11'd0);
        chk("vl0_busy", 32'(busy), 32'h0);
        push_exp(5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd2, 11'd3);

        // lmul8 group, vstart=2, vl=10, gaps between elements, upper bits ignored
        push_exp(5'd8,  4'hc, 32'h11100000, 1'b0, 1'b0);
        push_exp(5'd9,  4'hf, 32'h15141312, 1'b0, 1'b0);
        push_exp(5'd10, 4'h3, 32'h00001716, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) ed[k] = 32'hDEAD0010 + 32'(k);
        issue_cmd(5'd8, 2'd0, 2'd3, 11'd10, 11'd2);
        send_elems(8, 1);

        // sew16 over two registers
        push_exp(5'd2, 4'hf, 32'h22221111, 1'b0, 1'b0);
        push_exp(5'd3, 4'hf, 32'h44443333, 1'b1, 1'b0);
        ed[0] = 32'hFFFF1111; ed[1] = 32'hFFFF2222; ed[2] = 32'hFFFF3333; ed[3] = 32'hFFFF4444;
        issue_cmd(5'd2, 2'd1, 2'd1, 11'd4, 11'd0);
        send_elems(4, 0);

`ifdef RVV_WRITER_MASK_EN
        // masked element leaves its byte unstrobed
        push_exp(5'd0, 4'hd, 32'h04030001, 1'b1, 1'b0);
        ed[0] = 32'h01; ed[1] = 32'h02; ed[2] = 32'h03; ed[3] = 32'h04;
        em = 16'b1101;
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd4, 11'd0);
        send_elems(4, 0);
        // fully masked: no write, done still pulses
        push_exp(5'd0, 4'h0, 32'h0, 1'b1, 1'b0);
        em = 16'h0;
        issue_cmd(5'd0, 2'd0, 2'd0, 11'd4, 11'd0);
        send_elems(4, 0);
        em = '1;
`endif

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events got=%0d pending expected=0", exp_q.size());
            end
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
